// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - serial transmitter: start, 8 data bits LSB first, parity, stop
//
// Ports:
//   clk        - single clock, all state changes on its rising edge
//   reset      - asynchronous active-high reset
//   data_in    - byte to send, captured when a request is accepted
//   parity_bit - parity from the upstream stage, captured on accept, sent as-is
//   tx_start   - request to send; honoured only while idle, never queued
//   tx         - registered serial line, idle high
//   tx_busy    - high while a frame is in progress
//   tx_done    - one-cycle pulse as the block returns to idle

`timescale 1ns/1ps

module uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       parity_bit,
  input  logic       tx_start,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  // The stop state ends one cycle early: the final stop-bit cycle is the
  // IDLE/tx_done cycle, so a request accepted then starts the next frame with
  // no gap while the stop bit still lasts a full CLKS_PER_BIT cycles on tx.
  localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic [2:0]      r_idx;
  logic [2:0]      w_idx_next;
  logic [7:0]      r_data;
  logic            r_parity;
  logic            r_tx;
  logic            r_busy;
  logic            r_done;
  logic            w_tx_next;
  logic            w_busy_next;
  logic            w_done_next;
  logic            w_accept;
  logic            w_bit_end;
  logic            w_stop_end;

  assign w_accept   = (r_state == S_IDLE) && tx_start;
  assign w_bit_end  = (r_cnt == BIT_LAST);
  assign w_stop_end = (r_cnt == STOP_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (tx_start)                      w_state_next = S_START;
      S_START:  if (w_bit_end)                     w_state_next = S_DATA;
      S_DATA:   if (w_bit_end && (r_idx == 3'd7))  w_state_next = S_PARITY;
      S_PARITY: if (w_bit_end)                     w_state_next = S_STOP;
      S_STOP:   if (w_stop_end)                    w_state_next = S_IDLE;
      default:                                     w_state_next = S_IDLE;
    endcase
  end

  // Bit-period counter and data-bit index
  always_comb begin
    w_cnt_next = r_cnt + CW'(1);
    // Restart the bit period on every bit boundary and every state change;
    // held at zero while idle.
    if ((w_state_next == S_IDLE) || (w_state_next != r_state) || w_bit_end) begin
      w_cnt_next = '0;
    end
    w_idx_next = r_idx;
    // 3-bit index wraps 7 -> 0 as DATA hands over to PARITY.
    if ((r_state == S_DATA) && w_bit_end) begin
      w_idx_next = r_idx + 3'd1;
    end
  end

  // Output logic: computed from the next state so tx/tx_busy register on the
  // same edge as the state they describe.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = r_data[w_idx_next];
      S_PARITY: w_tx_next = r_parity;
      default:  w_tx_next = 1'b1;
    endcase
    w_busy_next = (w_state_next != S_IDLE);
    w_done_next = (r_state == S_STOP) && w_stop_end;
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_idx    <= 3'd0;
      r_data   <= 8'd0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_idx  <= w_idx_next;
      r_tx   <= w_tx_next;
      r_busy <= w_busy_next;
      r_done <= w_done_next;
      if (w_accept) begin
        r_data   <= data_in;
        r_parity <= parity_bit;
      end
    end
  end

  assign tx      = r_tx;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx

`timescale 1ns/1ps

module tb_uart_tx;

  localparam int CPB   = 16;
  localparam int FRAME = 11 * CPB;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       parity_bit;
  logic       tx_start;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int checks   = 0;
  int failures = 0;

  // Expected frames in line order: bit 0 = start, bits 1..8 = data LSB first,
  // bit 9 = parity, bit 10 = stop.
  logic [10:0] sb[$];

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .parity_bit (parity_bit),
    .tx_start   (tx_start),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  initial begin
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line monitor: pops one expected frame per start bit and checks every
  // cycle of the frame, plus tx_busy/tx_done across it.
  bit          mon_active = 1'b0;
  int          mon_cyc;
  int          mon_bad;
  int          mon_tbad;
  logic [10:0] mon_exp;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_active = 1'b0;
      end else begin
        if (!mon_active && (tx === 1'b0)) begin
          mon_active = 1'b1;
          mon_cyc    = 0;
          mon_bad    = 0;
          mon_tbad   = 0;
          check("frame_expected", (sb.size() > 0), 1);
          if (sb.size() > 0) mon_exp = sb.pop_front();
          else               mon_exp = 11'h7FF;
        end else if (mon_active) begin
          mon_cyc++;
        end
        if (mon_active) begin
          if (tx !== mon_exp[mon_cyc / CPB]) mon_bad++;
          if (mon_cyc < FRAME - 1) begin
            if ((tx_busy !== 1'b1) || (tx_done !== 1'b0)) mon_tbad++;
          end else begin
            if ((tx_busy !== 1'b0) || (tx_done !== 1'b1)) mon_tbad++;
          end
          if (mon_cyc == FRAME - 1) begin
            check("frame_bits", mon_bad, 0);
            check("done_timing", mon_tbad, 0);
            mon_active = 1'b0;
          end
        end
      end
    end
  end

  typedef struct {
    logic [7:0]  data;
    logic        par;
    logic [10:0] frame;
    bit          scramble;
    bit          poke;
  } vec_t;

  vec_t vecs[5];

  task automatic wait_idle(input string name);
    int n = 0;
    while ((tx_busy || mon_active) && (n < 2 * FRAME)) begin
      @(negedge clk);
      n++;
    end
    check(name, (tx_busy || mon_active), 0);
  endtask

  task automatic send(input vec_t v);
    @(posedge clk); #1;
    data_in    = v.data;
    parity_bit = v.par;
    tx_start   = 1'b1;
    sb.push_back(v.frame);
    @(posedge clk); #1;
    tx_start = 1'b0;
    check("accept_tx_low", tx, 0);
    check("accept_busy", tx_busy, 1);
    for (int i = 1; i < FRAME - 1; i++) begin
      if (v.scramble) begin
        data_in    = 8'($urandom_range(0, 255));
        parity_bit = 1'($urandom_range(0, 1));
      end
      if (v.poke && (i == 5 * CPB)) begin
        data_in    = 8'hAA;
        parity_bit = 1'b1;
        tx_start   = 1'b1;
      end else begin
        tx_start = 1'b0;
      end
      @(posedge clk); #1;
    end
    tx_start = 1'b0;
  endtask

  initial begin
    longint t1;
    longint t2;
    int     n;

    vecs[0] = '{8'h37, 1'b1, 11'h66E, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 11'h600, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 1'b0, 11'h5FE, 1'b1, 1'b0};
    vecs[3] = '{8'h55, 1'b1, 11'h6AA, 1'b0, 1'b0};
    vecs[4] = '{8'hBD, 1'b0, 11'h57A, 1'b1, 1'b1};

    // Reset with no clock running
    reset      = 1'b1;
    tx_start   = 1'b0;
    data_in    = 8'h00;
    parity_bit = 1'b0;
    #10;
    reset = 1'b0;
    #1;
    check("reset_tx", tx, 1);
    check("reset_busy", tx_busy, 0);
    check("reset_done", tx_done, 0);
    clk_run = 1'b1;

    // Table-driven frames
    for (int k = 0; k < 5; k++) begin
      send(vecs[k]);
      wait_idle("frame_complete");
      repeat (3 * CPB) @(negedge clk);
      check("stays_idle", {tx_busy, tx}, 2'b01);
    end

    // Back-to-back: second request issued in the tx_done cycle
    @(posedge clk); #1;
    data_in    = 8'h0F;
    parity_bit = 1'b0;
    tx_start   = 1'b1;
    sb.push_back(11'h41E);
    @(posedge clk); #1;
    tx_start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_done && (n < 2 * FRAME));
    check("b2b_first_done", tx_done, 1);
    t1         = $time;
    data_in    = 8'hA9;
    parity_bit = 1'b0;
    tx_start   = 1'b1;
    sb.push_back(11'h552);
    @(posedge clk); #1;
    tx_start = 1'b0;
    check("b2b_no_gap", tx, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_done && (n < 2 * FRAME));
    check("b2b_second_done", tx_done, 1);
    t2 = $time;
    check("b2b_done_spacing", 32'((t2 - t1) / 10), FRAME);
    wait_idle("b2b_complete");

    // Abort during DATA bit 3, then restart on the first edge after release
    @(posedge clk); #1;
    data_in    = 8'h55;
    parity_bit = 1'b1;
    tx_start   = 1'b1;
    sb.push_back(11'h6AA);
    @(posedge clk); #1;
    tx_start = 1'b0;
    repeat (4 * CPB + 5) @(posedge clk);
    #2;
    check("abort_pre_tx", tx, 0);
    reset = 1'b1;
    #1;
    check("abort_tx", tx, 1);
    check("abort_busy", tx_busy, 0);
    check("abort_done", tx_done, 0);
    repeat (2) @(negedge clk);
    reset      = 1'b0;
    data_in    = 8'hBD;
    parity_bit = 1'b0;
    tx_start   = 1'b1;
    sb.push_back(11'h57A);
    @(posedge clk); #1;
    tx_start = 1'b0;
    check("restart_tx_low", tx, 0);
    check("restart_busy", tx_busy, 1);
    wait_idle("restart_complete");

    repeat (2 * CPB) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range is 2 or more.
REQ-002 Port: clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 Port: reset, input, 1, asynchronous, active-high reset.
REQ-004 Port: data_in, input, 8, byte to transmit, sampled on accept.
REQ-005 Port: parity_bit, input, 1, parity from the upstream parity stage, sampled on accept and sent unchanged.
REQ-006 Port: tx_start, input, 1, request to send data_in/parity_bit.
REQ-007 Port: tx, output, 1, registered serial line, idle high.
REQ-008 Port: tx_busy, output, 1, high while a frame is in progress.
REQ-009 Port: tx_done, output, 1, one-cycle pulse at the end of a frame.

Function
REQ-010 The frame SHALL be: start bit (0), data_in[0] through data_in[7] (LSB first), parity_bit, and stop bit (1), for 11 bits in total.
REQ-011 Each bit SHALL be held on tx for exactly CLKS_PER_BIT cycles, so a frame is 11*CLKS_PER_BIT cycles.
REQ-012 The state machine SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-013 Transitions SHALL be:
  - IDLE to START on accept;
  - START to DATA after CLKS_PER_BIT cycles;
  - DATA to PARITY after 8 bits;
  - PARITY to STOP after CLKS_PER_BIT cycles;
  - STOP to IDLE after CLKS_PER_BIT cycles.
REQ-014 Accept SHALL occur when tx_start=1 and state=IDLE at a clock edge; data_in and parity_bit SHALL be latched into internal registers at that edge.
REQ-015 tx SHALL go low on the first clock edge after the accept cycle (one-cycle latency); tx_busy SHALL rise on the same edge.
REQ-016 A tx_start asserted when the state is not IDLE SHALL be ignored and not queued; the latched data SHALL not change mid-frame.
REQ-017 Changes on data_in and parity_bit after accept SHALL not affect the frame in progress.
REQ-018 A bit-period counter SHALL count from 0 to CLKS_PER_BIT-1, be sized to clog2(CLKS_PER_BIT), wrap to 0 at each bit boundary, and be held at 0 in IDLE.
REQ-019 A 3-bit index SHALL select the data bit; it SHALL wrap from 7 to 0 on the transition to PARITY.
REQ-020 tx_done SHALL be high for exactly the single cycle in which the state returns to IDLE, coincident with tx_busy falling.
REQ-021 Back-to-back frames:
  - a tx_start in the tx_done cycle SHALL be accepted;
  - the next start bit SHALL then follow the stop bit with no idle gap.
REQ-022 In IDLE, tx SHALL be 1 and tx_busy SHALL be 0.

Reset
REQ-023 While reset=1, the block SHALL immediately, without waiting for a clock, force:
  - tx=1, tx_busy=0, tx_done=0;
  - state=IDLE;
  - both counters to 0;
  - the latched data and parity registers to 0.
REQ-024 A reset asserted mid-frame SHALL abort the frame; after release the block SHALL be idle and SHALL accept a new tx_start on the first clock edge.

Verification
REQ-025 Reset: assert reset for 10 ns, then release -> tx=1, tx_busy=0, tx_done=0 before any clock edge.
REQ-026 Single frame: CLKS_PER_BIT=16, data_in=8'b00110111, parity_bit=1, tx_start for 1 cycle -> line sequence 0,1,1,1,0,1,1,0,0,1,1, each bit 16 cycles; tx_done pulses at cycle 176 after accept.
REQ-027 Ignored start: pulse tx_start with data_in=8'hAA mid-frame -> frame unchanged, no second frame.
REQ-028 Back-to-back: data_in=8'h0F with parity 0, then tx_start in the tx_done cycle with data_in=8'hA9 and parity 0 -> two contiguous 11-bit frames, two tx_done pulses 176 cycles apart.
REQ-029 Abort: assert reset during DATA bit 3 -> tx=1 immediately; a new frame with 8'hBD and parity 0 transmits correctly after release.
REQ-030 Input change: alter data_in and parity_bit every cycle after accept -> the transmitted bits match the values latched at accept.
